// File: rtl/noc_flit_rx_decoder.sv
// noc_flit_rx_decoder
// Receive side of the 608-bit LHS link (Cheetah -> FPGA). Accepts one flit per
// cycle, decodes the header and steers traffic:
//   - single-flit cache read requests  -> scheduler request slot (sc_req_*)
//   - multi-flit DMA write packets     -> DMA engine, one 512-bit beat per
//                                         payload flit with its own address
// Sequence numbers, head and tail placement are checked. A malformed packet
// is dropped through DRAIN, and an error pulse is raised for it.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   lhs_in_data/valid        inbound flit and its valid strobe
//   lhs_ready                flit consumed when lhs_in_valid & lhs_ready
//   sc_req_*                 scheduler read request (valid/ready + fields)
//   dma_wr_*                 DMA write beat (valid/ready + addr/data/ids/beat/last)
//   err_seq, err_unknown     one-cycle error pulses
//   err_count                saturating total error count
module noc_flit_rx_decoder #(
  parameter int LEN_ADDR         = 32,
  parameter int LEN_PROCESSOR_NO = 7,
  parameter int LEN_SLOT_ID      = 7,
  parameter int PACKT_LEN        = 13,
  parameter int LEN_DATA_LHS     = 608,
  parameter int LEN_DATA_RHS     = 512,
  parameter int ADDR_STRIDE      = 64,
  parameter logic [4:0] MSG_RD_REQ = 5'd1,
  parameter logic [4:0] MSG_DMA_WR = 5'd5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LEN_DATA_LHS-1:0]     lhs_in_data,
  input  logic                        lhs_in_valid,
  output logic                        lhs_ready,
  output logic                        sc_req_valid,
  input  logic                        sc_req_ready,
  output logic [LEN_ADDR-1:0]         sc_req_addr,
  output logic [LEN_PROCESSOR_NO-1:0] sc_req_processor_id,
  output logic [LEN_SLOT_ID-1:0]      sc_req_slot_id,
  output logic                        dma_wr_valid,
  input  logic                        dma_wr_ready,
  output logic [LEN_ADDR-1:0]         dma_wr_addr,
  output logic [LEN_DATA_RHS-1:0]     dma_wr_data,
  output logic [LEN_PROCESSOR_NO-1:0] dma_wr_processor_id,
  output logic [LEN_SLOT_ID-1:0]      dma_wr_slot_id,
  output logic [PACKT_LEN-1:0]        dma_wr_beat,
  output logic                        dma_wr_last,
  output logic                        err_seq,
  output logic                        err_unknown,
  output logic [15:0]                 err_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // Header field decode
  logic                        f_valid_s;
  logic                        f_tail_s;
  logic                        f_head_s;
  logic [LEN_PROCESSOR_NO-1:0] f_src_s;
  logic [4:0]                  f_msg_s;
  logic [LEN_SLOT_ID-1:0]      f_slot_s;
  logic [4:0]                  f_seq_s;
  logic [4:0]                  f_tx_s;
  logic [6:0]                  f_pkt_s;
  logic [LEN_ADDR-1:0]         f_addr_s;
  logic [LEN_DATA_RHS-1:0]     f_payload_s;
  logic                        unused_flit_bits_s;

  assign f_valid_s   = lhs_in_data[607];
  assign f_tail_s    = lhs_in_data[606];
  assign f_src_s     = lhs_in_data[584 +: LEN_PROCESSOR_NO];
  assign f_msg_s     = lhs_in_data[580:576];
  assign f_slot_s    = lhs_in_data[568 +: LEN_SLOT_ID];
  assign f_seq_s     = lhs_in_data[565:561];
  assign f_tx_s      = lhs_in_data[560:556];
  assign f_head_s    = lhs_in_data[555];
  assign f_pkt_s     = lhs_in_data[554:548];
  assign f_addr_s    = lhs_in_data[512 +: LEN_ADDR];
  assign f_payload_s = lhs_in_data[LEN_DATA_RHS-1:0];
  // Reserved header bits and the upper Dram_addr bits carry nothing for this block.
  assign unused_flit_bits_s = ^lhs_in_data;

  // State and slot registers
  state_e                      state_q, state_d;
  logic [PACKT_LEN-1:0]        beat_q, beat_d;
  logic [PACKT_LEN-1:0]        total_q, total_d;
  logic [LEN_ADDR-1:0]         base_q, base_d;
  logic [LEN_PROCESSOR_NO-1:0] pid_q, pid_d;
  logic [LEN_SLOT_ID-1:0]      slot_q, slot_d;

  logic                        sc_valid_q, sc_valid_d;
  logic [LEN_ADDR-1:0]         sc_addr_q, sc_addr_d;
  logic [LEN_PROCESSOR_NO-1:0] sc_pid_q, sc_pid_d;
  logic [LEN_SLOT_ID-1:0]      sc_slot_q, sc_slot_d;

  logic                        dma_valid_q, dma_valid_d;
  logic [LEN_ADDR-1:0]         dma_addr_q, dma_addr_d;
  logic [LEN_DATA_RHS-1:0]     dma_data_q, dma_data_d;
  logic [LEN_PROCESSOR_NO-1:0] dma_pid_q, dma_pid_d;
  logic [LEN_SLOT_ID-1:0]      dma_slot_q, dma_slot_d;
  logic [PACKT_LEN-1:0]        dma_beat_q, dma_beat_d;
  logic                        dma_last_q, dma_last_d;

  logic                        err_seq_q, err_seq_d;
  logic                        err_unk_q, err_unk_d;
  logic [15:0]                 err_cnt_q, err_cnt_d;

  logic                        accept_s;
  logic                        good_beat_s;
  logic [LEN_ADDR-1:0]         beat_offset_s;

  // A full slot whose consumer is not ready blocks the link; reset also blocks it.
  assign lhs_ready = rst & ~(sc_valid_q & ~sc_req_ready) & ~(dma_valid_q & ~dma_wr_ready);
  assign accept_s  = lhs_in_valid & lhs_ready;

  assign good_beat_s = ~f_head_s
                     & (f_seq_s == beat_q[4:0])
                     & (f_tail_s == (beat_q == (total_q - PACKT_LEN'(1))));

  // Address wraps modulo 2^LEN_ADDR.
  assign beat_offset_s = LEN_ADDR'(beat_q) * LEN_ADDR'(ADDR_STRIDE);

  // Next-state, slot loading and error decode for each accepted flit.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    total_d     = total_q;
    base_d      = base_q;
    pid_d       = pid_q;
    slot_d      = slot_q;
    sc_valid_d  = sc_valid_q & ~sc_req_ready;
    sc_addr_d   = sc_addr_q;
    sc_pid_d    = sc_pid_q;
    sc_slot_d   = sc_slot_q;
    dma_valid_d = dma_valid_q & ~dma_wr_ready;
    dma_addr_d  = dma_addr_q;
    dma_data_d  = dma_data_q;
    dma_pid_d   = dma_pid_q;
    dma_slot_d  = dma_slot_q;
    dma_beat_d  = dma_beat_q;
    dma_last_d  = dma_last_q;
    err_seq_d   = 1'b0;
    err_unk_d   = 1'b0;

    // Bubble flits (Valid bit clear) are consumed without any effect.
    if (accept_s && f_valid_s) begin
      case (state_q)
        ST_IDLE: begin
          if (f_head_s) begin
            if (f_msg_s == MSG_RD_REQ) begin
              if (f_tail_s) begin
                sc_valid_d = 1'b1;
                sc_addr_d  = f_addr_s;
                sc_pid_d   = f_src_s;
                sc_slot_d  = f_slot_s;
              end else begin
                err_seq_d = 1'b1;
                state_d   = ST_DRAIN;
              end
            end else if (f_msg_s == MSG_DMA_WR) begin
              if (!f_tail_s) begin
                base_d  = f_addr_s;
                pid_d   = f_src_s;
                slot_d  = f_slot_s;
                // PKT_Count*32 + TX_Count is the concatenation of the two fields.
                total_d = PACKT_LEN'({f_pkt_s, f_tx_s}) + PACKT_LEN'(1);
                beat_d  = '0;
                state_d = ST_PAYLOAD;
              end else begin
                err_seq_d = 1'b1;
              end
            end else begin
              err_unk_d = 1'b1;
              state_d   = f_tail_s ? ST_IDLE : ST_DRAIN;
            end
          end else begin
            err_seq_d = 1'b1;
            state_d   = f_tail_s ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_PAYLOAD: begin
          if (good_beat_s) begin
            dma_valid_d = 1'b1;
            dma_addr_d  = base_q + beat_offset_s;
            dma_data_d  = f_payload_s;
            dma_pid_d   = pid_q;
            dma_slot_d  = slot_q;
            dma_beat_d  = beat_q;
            dma_last_d  = f_tail_s;
            beat_d      = beat_q + PACKT_LEN'(1);
            state_d     = f_tail_s ? ST_IDLE : ST_PAYLOAD;
          end else begin
            err_seq_d = 1'b1;
            state_d   = f_tail_s ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_d = f_tail_s ? ST_IDLE : ST_DRAIN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if ((err_seq_d || err_unk_d) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, slot and error registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      total_q     <= '0;
      base_q      <= '0;
      pid_q       <= '0;
      slot_q      <= '0;
      sc_valid_q  <= 1'b0;
      sc_addr_q   <= '0;
      sc_pid_q    <= '0;
      sc_slot_q   <= '0;
      dma_valid_q <= 1'b0;
      dma_addr_q  <= '0;
      dma_data_q  <= '0;
      dma_pid_q   <= '0;
      dma_slot_q  <= '0;
      dma_beat_q  <= '0;
      dma_last_q  <= 1'b0;
      err_seq_q   <= 1'b0;
      err_unk_q   <= 1'b0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      total_q     <= total_d;
      base_q      <= base_d;
      pid_q       <= pid_d;
      slot_q      <= slot_d;
      sc_valid_q  <= sc_valid_d;
      sc_addr_q   <= sc_addr_d;
      sc_pid_q    <= sc_pid_d;
      sc_slot_q   <= sc_slot_d;
      dma_valid_q <= dma_valid_d;
      dma_addr_q  <= dma_addr_d;
      dma_data_q  <= dma_data_d;
      dma_pid_q   <= dma_pid_d;
      dma_slot_q  <= dma_slot_d;
      dma_beat_q  <= dma_beat_d;
      dma_last_q  <= dma_last_d;
      err_seq_q   <= err_seq_d;
      err_unk_q   <= err_unk_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign sc_req_valid        = sc_valid_q;
  assign sc_req_addr         = sc_addr_q;
  assign sc_req_processor_id = sc_pid_q;
  assign sc_req_slot_id      = sc_slot_q;
  assign dma_wr_valid        = dma_valid_q;
  assign dma_wr_addr         = dma_addr_q;
  assign dma_wr_data         = dma_data_q;
  assign dma_wr_processor_id = dma_pid_q;
  assign dma_wr_slot_id      = dma_slot_q;
  assign dma_wr_beat         = dma_beat_q;
  assign dma_wr_last         = dma_last_q;
  assign err_seq             = err_seq_q;
  assign err_unknown         = err_unk_q;
  assign err_count           = err_cnt_q;

endmodule

// File: tb/tb_noc_flit_rx_decoder.sv
// Scoreboard bench for noc_flit_rx_decoder: stimulus pushes expected sc/dma/error
// events into queues, a negedge monitor pops and compares on each handshake.
module tb_noc_flit_rx_decoder;

  logic         clk;
  logic         rst;
  logic [607:0] lhs_in_data;
  logic         lhs_in_valid;
  logic         lhs_ready;
  logic         sc_req_valid;
  logic         sc_req_ready;
  logic [31:0]  sc_req_addr;
  logic [6:0]   sc_req_processor_id;
  logic [6:0]   sc_req_slot_id;
  logic         dma_wr_valid;
  logic         dma_wr_ready;
  logic [31:0]  dma_wr_addr;
  logic [511:0] dma_wr_data;
  logic [6:0]   dma_wr_processor_id;
  logic [6:0]   dma_wr_slot_id;
  logic [12:0]  dma_wr_beat;
  logic         dma_wr_last;
  logic         err_seq;
  logic         err_unknown;
  logic [15:0]  err_count;

  noc_flit_rx_decoder dut (
    .clk                 (clk),
    .rst                 (rst),
    .lhs_in_data         (lhs_in_data),
    .lhs_in_valid        (lhs_in_valid),
    .lhs_ready           (lhs_ready),
    .sc_req_valid        (sc_req_valid),
    .sc_req_ready        (sc_req_ready),
    .sc_req_addr         (sc_req_addr),
    .sc_req_processor_id (sc_req_processor_id),
    .sc_req_slot_id      (sc_req_slot_id),
    .dma_wr_valid        (dma_wr_valid),
    .dma_wr_ready        (dma_wr_ready),
    .dma_wr_addr         (dma_wr_addr),
    .dma_wr_data         (dma_wr_data),
    .dma_wr_processor_id (dma_wr_processor_id),
    .dma_wr_slot_id      (dma_wr_slot_id),
    .dma_wr_beat         (dma_wr_beat),
    .dma_wr_last         (dma_wr_last),
    .err_seq             (err_seq),
    .err_unknown         (err_unknown),
    .err_count           (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  pid;
    logic [6:0]  slot;
  } sc_exp_t;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
    logic [12:0]  beat;
    logic         last;
    logic [6:0]   pid;
    logic [6:0]   slot;
  } dma_exp_t;

  sc_exp_t  sc_q[$];
  dma_exp_t dma_q[$];
  logic     err_q[$];   // 0 = err_seq, 1 = err_unknown

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    checks++;
    $display("FAIL %s: got an output, expected none", name);
  endtask

  // Monitor: pops and compares whenever the DUT presents a transfer or pulse.
  always @(negedge clk) begin
    if (sc_req_valid && sc_req_ready) begin
      if (sc_q.size() == 0) unexpected("sc_req");
      else begin
        sc_exp_t e;
        e = sc_q.pop_front();
        chk("sc_addr", sc_req_addr, e.addr);
        chk("sc_pid", sc_req_processor_id, e.pid);
        chk("sc_slot", sc_req_slot_id, e.slot);
      end
    end
    if (dma_wr_valid && dma_wr_ready) begin
      if (dma_q.size() == 0) unexpected("dma_wr");
      else begin
        dma_exp_t d;
        d = dma_q.pop_front();
        chk("dma_addr", dma_wr_addr, d.addr);
        chk("dma_data", dma_wr_data, d.data);
        chk("dma_beat", dma_wr_beat, d.beat);
        chk("dma_last", dma_wr_last, d.last);
        chk("dma_pid", dma_wr_processor_id, d.pid);
        chk("dma_slot", dma_wr_slot_id, d.slot);
      end
    end
    if (err_seq || err_unknown) begin
      if (err_q.size() == 0) unexpected("err_pulse");
      else begin
        logic k;
        k = err_q.pop_front();
        chk("err_seq_pulse", err_seq, !k);
        chk("err_unknown_pulse", err_unknown, k);
      end
    end
  end

  function automatic logic [607:0] mk(input logic v, input logic t, input logic h,
                                      input logic [4:0] msg, input logic [6:0] src,
                                      input logic [6:0] slot, input logic [4:0] seq,
                                      input logic [4:0] tx, input logic [6:0] pkt,
                                      input logic [35:0] addr, input logic [511:0] pl);
    logic [607:0] f;
    f = '0;
    f[607] = v;         f[606] = t;
    f[590:584] = src;   f[580:576] = msg;
    f[574:568] = slot;  f[565:561] = seq;
    f[560:556] = tx;    f[555] = h;
    f[554:548] = pkt;   f[547:512] = addr;
    f[511:0] = pl;
    return f;
  endfunction

  function automatic logic [511:0] pat(input int k);
    logic [31:0] w;
    w = 32'hCAFE_0000 + 32'(k);
    return {16{w}};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a flit and holds it until it is accepted (bounded wait).
  task automatic send(input logic [607:0] f);
    logic acc;
    int   n;
    lhs_in_data  = f;
    lhs_in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = lhs_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: got lhs_ready=0 for %0d cycles, expected acceptance", n);
    end
    lhs_in_valid = 1'b0;
  endtask

  task automatic rd(input logic [35:0] addr, input logic [6:0] pid, input logic [6:0] slot,
                    input logic [31:0] exp_addr);
    sc_exp_t e;
    e.addr = exp_addr; e.pid = pid; e.slot = slot;
    sc_q.push_back(e);
    send(mk(1'b1, 1'b1, 1'b1, 5'd1, pid, slot, 5'd0, 5'd0, 7'd0, addr, 512'd0));
  endtask

  task automatic hdr(input logic [4:0] tx, input logic [6:0] pkt, input logic [35:0] addr,
                     input logic [6:0] pid, input logic [6:0] slot);
    send(mk(1'b1, 1'b0, 1'b1, 5'd5, pid, slot, 5'd0, tx, pkt, addr, 512'd0));
  endtask

  task automatic pay(input logic [4:0] seq, input logic tail, input logic [511:0] pl);
    send(mk(1'b1, tail, 1'b0, 5'd5, 7'd0, 7'd0, seq, 5'd0, 7'd0, 36'd0, pl));
  endtask

  task automatic dexp(input logic [31:0] addr, input logic [511:0] data, input logic [12:0] beat,
                      input logic last, input logic [6:0] pid, input logic [6:0] slot);
    dma_exp_t d;
    d.addr = addr; d.data = data; d.beat = beat; d.last = last; d.pid = pid; d.slot = slot;
    dma_q.push_back(d);
  endtask

  initial begin
    rst          = 1'b0;
    lhs_in_data  = '0;
    lhs_in_valid = 1'b0;
    sc_req_ready = 1'b1;
    dma_wr_ready = 1'b1;
    idle(3);

    // Reset state
    @(negedge clk);
    chk("rst_lhs_ready", lhs_ready, 0);
    chk("rst_sc_valid", sc_req_valid, 0);
    chk("rst_dma_valid", dma_wr_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_dma_beat", dma_wr_beat, 0);
    chk("rst_dma_last", dma_wr_last, 0);
    chk("rst_dma_addr", dma_wr_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // 1: read request, 36-bit address truncated to 32 bits
    rd(36'h1_2345_6780, 7'd5, 7'd9, 32'h2345_6780);
    idle(2);

    // 2: three-beat DMA write with a bubble flit in the middle, then a read
    hdr(5'd2, 7'd0, 36'h1000, 7'd3, 7'd4);
    dexp(32'h1000, pat(0), 13'd0, 1'b0, 7'd3, 7'd4);
    pay(5'd0, 1'b0, pat(0));
    send(mk(1'b0, 1'b1, 1'b1, 5'd1, 7'd1, 7'd1, 5'd0, 5'd0, 7'd0, 36'hDEAD, 512'd0));
    dexp(32'h1040, pat(1), 13'd1, 1'b0, 7'd3, 7'd4);
    pay(5'd1, 1'b0, pat(1));
    dexp(32'h1080, pat(2), 13'd2, 1'b1, 7'd3, 7'd4);
    pay(5'd2, 1'b1, pat(2));
    rd(36'h0_0000_0040, 7'd11, 7'd12, 32'h0000_0040);
    idle(2);

    // 3: DMA consumer stalls for 5 cycles after beat 0
    hdr(5'd2, 7'd0, 36'h8000, 7'd1, 7'd2);
    dexp(32'h8000, pat(10), 13'd0, 1'b0, 7'd1, 7'd2);
    pay(5'd0, 1'b0, pat(10));
    dexp(32'h8040, pat(11), 13'd1, 1'b0, 7'd1, 7'd2);
    pay(5'd1, 1'b0, pat(11));
    dma_wr_ready = 1'b0;
    lhs_in_data  = mk(1'b1, 1'b1, 1'b0, 5'd5, 7'd0, 7'd0, 5'd2, 5'd0, 7'd0, 36'd0, pat(12));
    lhs_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_lhs_ready", lhs_ready, 0);
      chk("stall_hold_beat", dma_wr_beat, 1);
      @(posedge clk);
      #1;
    end
    dma_wr_ready = 1'b1;
    dexp(32'h8080, pat(12), 13'd2, 1'b1, 7'd1, 7'd2);
    pay(5'd2, 1'b1, pat(12));
    idle(2);

    // 4: sequence gap -> error, drain to tail, then a read is served
    hdr(5'd3, 7'd0, 36'h5000, 7'd6, 7'd7);
    dexp(32'h5000, pat(20), 13'd0, 1'b0, 7'd6, 7'd7);
    pay(5'd0, 1'b0, pat(20));
    err_q.push_back(1'b0);
    pay(5'd2, 1'b0, pat(22));
    pay(5'd3, 1'b1, pat(23));
    rd(36'h0_ABCD_0000, 7'd2, 7'd3, 32'hABCD_0000);
    idle(3);
    chk("seq_gap_err_count", err_count, 1);

    // Unknown message type with tail -> err_unknown, stays idle
    err_q.push_back(1'b1);
    send(mk(1'b1, 1'b1, 1'b1, 5'd7, 7'd0, 7'd0, 5'd0, 5'd0, 7'd0, 36'd0, 512'd0));
    rd(36'h0_0000_0100, 7'd4, 7'd4, 32'h0000_0100);
    idle(3);
    chk("unknown_err_count", err_count, 2);

    // 5: 34-beat packet, sequence wraps 31 -> 0 at beat 32
    hdr(5'd1, 7'd1, 36'h2000, 7'd8, 7'd9);
    for (int i = 0; i < 34; i++) begin
      dexp(32'h2000 + 32'(i * 64), pat(100 + i), 13'(i), (i == 33), 7'd8, 7'd9);
      pay(5'(i % 32), (i == 33), pat(100 + i));
    end
    idle(3);
    chk("wrap_err_count", err_count, 2);

    // 6: reset mid-packet, orphan payload flits give one error
    hdr(5'd2, 7'd0, 36'h3000, 7'd1, 7'd1);
    dexp(32'h3000, pat(200), 13'd0, 1'b0, 7'd1, 7'd1);
    pay(5'd0, 1'b0, pat(200));
    idle(2);
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    chk("midrst_lhs_ready", lhs_ready, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_dma_valid", dma_wr_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    err_q.push_back(1'b0);
    pay(5'd1, 1'b0, pat(201));
    pay(5'd2, 1'b1, pat(202));
    idle(3);
    chk("orphan_err_count", err_count, 1);
    rd(36'h0_0000_0200, 7'd3, 7'd5, 32'h0000_0200);

    idle(10);
    chk("sc_queue_empty", sc_q.size(), 0);
    chk("dma_queue_empty", dma_q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/noc_flit_rx_decoder.md
# noc_flit_rx_decoder

Inbound (Cheetah→FPGA) flit receiver on the 608-bit LHS link. It accepts flits, decodes the header fields and routes traffic to two consumers:
- single-flit cache read requests go to the scheduler;
- multi-flit DMA write packets go to the DMA engine as one 512-bit beat per payload flit, with a per-beat address.

It checks sequence numbers and tail placement, discards malformed packets and counts errors. It is the receive-side counterpart of the forwarding unit that builds outbound flits.

## Interface
Parameters:
- LEN_ADDR, 32, output address width; header Dram_addr[547:512] is truncated to its low LEN_ADDR bits.
- LEN_PROCESSOR_NO, 7, processor id width.
- LEN_SLOT_ID, 7, slot id width.
- PACKT_LEN, 13, beat-count width (max 4096 payload flits).
- LEN_DATA_LHS, 608, flit width.
- LEN_DATA_RHS, 512, payload width.
- ADDR_STRIDE, 64, byte increment per payload beat.
- MSG_RD_REQ, 5'd1, msg type for a cache read request.
- MSG_DMA_WR, 5'd5, msg type for a DMA write packet.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- lhs_in_data  in  608  flit. Field map: Valid 607, Tail 606, SRC_Dest 590:584, Msg_type 580:576, SLOT_ID 574:568, SEQ_NUM 565:561, TX_Count 560:556, Head 555, PKT_Count 554:548, Dram_addr 547:512, Payload 511:0.
- lhs_in_valid  in  1  flit present.
- lhs_ready  out  1  flit consumed on the edge where lhs_in_valid & lhs_ready.
- sc_req_valid / sc_req_ready  out / in  1 / 1  scheduler request handshake.
- sc_req_addr, sc_req_processor_id, sc_req_slot_id  out  LEN_ADDR / 7 / 7  request fields.
- dma_wr_valid / dma_wr_ready  out / in  1 / 1  DMA beat handshake.
- dma_wr_addr, dma_wr_data  out  LEN_ADDR / 512  beat address and payload.
- dma_wr_processor_id, dma_wr_slot_id  out  7 / 7  ids latched from the header.
- dma_wr_beat  out  PACKT_LEN  beat index, 0-based.
- dma_wr_last  out  1  final beat of the packet.
- err_seq  out  1  one-cycle pulse on a sequence, tail or head violation.
- err_unknown  out  1  one-cycle pulse on an unknown msg type.
- err_count  out  16  saturating count of all errors.

## Operation
- **States:** IDLE, PAYLOAD, DRAIN (2-bit encoding).
- **Output slots:** sc and dma each have a one-entry output register. lhs_ready = ~(sc_req_valid & ~sc_req_ready) & ~(dma_wr_valid & ~dma_wr_ready). It is combinational from the ready inputs.
- **Bubble flits:** an accepted flit with Valid bit = 0 is consumed and ignored in every state. It causes no error and no state change.
- **IDLE, Head=1, msg MSG_RD_REQ, Tail=1:** load the sc slot with addr = Dram_addr[LEN_ADDR-1:0], processor_id = SRC_Dest, slot_id = SLOT_ID. Stay in IDLE.
- **IDLE, Head=1, msg MSG_DMA_WR, Tail=0:** latch base address, ids, and total = PKT_Count·32 + TX_Count + 1 (PACKT_LEN bits). Clear beat. Go to PAYLOAD.
- **IDLE, Head=1, RD with Tail=0 or WR with Tail=1:** err_seq. RD with Tail=0 goes to DRAIN; WR with Tail=1 stays in IDLE.
- **IDLE, Head=1, any other msg type:** err_unknown. Tail=1 stays in IDLE; Tail=0 goes to DRAIN.
- **IDLE, Head=0:** err_seq. Go to DRAIN, or stay in IDLE if Tail=1.
- **PAYLOAD, per accepted flit:**
  - The flit is good if Head=0, SEQ_NUM == beat[4:0], and Tail == (beat == total-1).
  - Good: load the dma slot with addr = base + beat·ADDR_STRIDE (modulo 2^LEN_ADDR), data = Payload, dma_wr_last = Tail. Increment beat. The last beat returns to IDLE.
  - Bad: err_seq and drop the flit. Tail=1 goes to IDLE; otherwise go to DRAIN.
- **DRAIN:** discard flits until one with Tail=1 is accepted, then go to IDLE. No further errors are raised in DRAIN.
- **err_count:** increments on each err_seq or err_unknown pulse and saturates at 0xFFFF.

## Timing
- **Reset values:** state IDLE; all valid outputs, error pulses, err_count, dma_wr_last and dma_wr_beat are 0; address/data registers are 0; lhs_ready is 0 while rst = 0.
- **Latency:** a flit accepted at edge k produces its output valid after edge k; error pulses are high for the cycle after edge k.
- **Throughput:** one flit per cycle when the consumers keep ready high.
- **Output hold:** valid stays high with all fields stable until its ready is seen; it is cleared on that edge unless reloaded on the same edge.
- **Slot clearing:** a slot whose ready is high can be cleared and reloaded on the same edge.
- **Reset mid-packet:** abandons the packet. Orphan payload flits that follow are handled as IDLE Head=0: one error, then DRAIN.
- **Sequence wrap:** SEQ_NUM wraps 31→0 across 32-beat groups. beat is PACKT_LEN bits wide and never wraps within a legal packet.

## Test plan
1. RD request, addr 0x1_2345_6780, pid 5, slot 9 → sc_req_valid one cycle later with addr 0x23456780, pid 5, slot 9; no DMA activity.
2. WR header TX_Count=2, PKT_Count=0, addr 0x1000, then seq 0,1,2 (tail on seq 2) → three dma beats at 0x1000, 0x1040, 0x1080; beat 0,1,2; last only on the third; FSM back in IDLE.
3. Test 2 with dma_wr_ready low for 5 cycles after beat 0 → lhs_ready low for those 5 cycles; no beat lost or duplicated; data is order-preserved.
4. WR header with TX_Count=3, payloads with seq 0 then 2 → one beat emitted; err_seq pulse; err_count=1; remaining flits drained through tail; following RD served normally.
5. WR header with PKT_Count=1, TX_Count=1 → 34 beats; SEQ_NUM wraps 31→0 at beat 32; last asserted on beat 33 only.
6. Reset asserted after 1 of 3 payload beats, then the remaining 2 flits (second carries tail) → one err_seq; both flits discarded; no dma output; err_count=1.
